mult_arbiter: RTL and testbench
===============================

MULT_ARBITER -- requirements
Module: mult_arbiter

Interface
REQ-001 Parameter: N, default 4, operand width in bits; product width is 2N.
REQ-002 Parameter: NREQ, default 2, number of requesters, legal range 2..4.
REQ-003 Parameter: TIMEOUT_CYCLES, default 255, watchdog limit in clocks; used only when MULT_ARB_TIMEOUT_EN is defined.
REQ-004 Port: clock  input  1  single clock; all logic is rising-edge.
REQ-005 Port: reset  input  1  asynchronous, active-high reset.
REQ-006 Port: req_valid  input  NREQ  per-requester level request.
REQ-007 Port: req_multiplicand, req_multiplier  input  NREQ*N each  packed operands; slice i belongs to requester i.
REQ-008 Port: req_ack  output  NREQ  one-cycle pulse; operands of requester i captured.
REQ-009 Port: rsp_valid  output  NREQ  one-cycle pulse; result for requester i.
REQ-010 Port: rsp_product  output  2N  shared result bus, valid when any rsp_valid bit is high.
REQ-011 Port: rsp_error  output  NREQ  one-cycle pulse flagging timeout abort; tied 0 without the macro.
REQ-012 Port: mult_start  output  1  start strobe to the shared multiplier.
REQ-013 Port: mult_multiplicand, mult_multiplier  output  N each  registered operands to the multiplier.
REQ-014 Port: mult_ready  input  1  multiplier idle/done flag.
REQ-015 Port: mult_product  input  2N  multiplier result, valid while mult_ready is high after completion.

Function
REQ-016 FSM states SHALL be IDLE, START, BUSY, RESP.
REQ-017 IDLE: when any req_valid bit is set and mult_ready=1, grant one requester, pulse its req_ack, latch its operands into mult_* registers, latch grant index, go to START.
REQ-018 Grant SHALL be round-robin: search starts at (last_grant+1) mod NREQ; last_grant resets to NREQ-1, so requester 0 wins the first grant.
REQ-019 START: hold mult_start=1 until mult_ready=0 is sampled, then go to BUSY; mult_start=0 in every other state.
REQ-020 BUSY: on mult_ready=1, register mult_product into rsp_product and go to RESP.
REQ-021 RESP: pulse rsp_valid[grant] for exactly one cycle, then return to IDLE; no new grant is issued in RESP.
REQ-022 Operand outputs SHALL stay stable from START entry until RESP exit.
REQ-023 Minimum request-to-request spacing is 4 cycles (IDLE, START, BUSY, RESP); back-to-back requests SHALL alternate when both are held.
REQ-024 req_valid deasserting after req_ack SHALL NOT affect the operation in flight.
REQ-025 rsp_product SHALL hold its last value between responses.

Reset
REQ-026 On reset: state=IDLE; req_ack, rsp_valid, rsp_error and mult_start = 0; mult_* operands = 0; rsp_product = 0; last_grant = NREQ-1; watchdog = 0.
REQ-027 Reset asserted mid-operation SHALL abort it immediately with no rsp_valid or rsp_error pulse.

Configuration
REQ-028 With MULT_ARB_TIMEOUT_EN defined: a watchdog counts cycles spent in START+BUSY; on reaching TIMEOUT_CYCLES, pulse rsp_error[grant] for one cycle (rsp_valid stays 0), drop mult_start, and return to IDLE.
REQ-029 Without MULT_ARB_TIMEOUT_EN: no watchdog logic is built; rsp_error is constant 0; the FSM waits indefinitely.

Structure
REQ-030 Package mult_arb_pkg SHALL hold the state enum (mult_arb_state_t) and the default TIMEOUT_CYCLES constant.
REQ-031 The round-robin selector SHALL be a sub-module, rr_select (inputs: request vector, last grant; outputs: found flag, grant index).

Verification
REQ-032 Single request: N=4, req_valid=01, operands 7 and 9; model drops ready 1 cycle after start and raises it 3 cycles later -> req_ack[0] once, then rsp_valid[0] once with rsp_product=63.
REQ-033 Contention: both requesters held (3x5 and 15x15) -> grants 0,1,0,1; products 15 and 225 routed to the matching rsp_valid bit.
REQ-034 Boundary operands: 0x0 and 15x15 -> products 0 and 225 (0xE1); no width truncation.
REQ-035 Reset mid-operation: reset in BUSY -> all outputs 0 within the same cycle, no response pulses; next request is granted to requester 0.
REQ-036 Timeout (macro on, TIMEOUT_CYCLES=8): mult_ready never falls -> rsp_error[grant] pulses after 8 cycles, rsp_valid stays 0; FSM returns to IDLE and serves the next request normally.
REQ-037 Slow multiplier: ready low for 1000 cycles -> mult_start is held only until ready falls, and operands stay stable throughout.

Source files
------------

// File: rtl/mult_arb_pkg.sv
// rtl/mult_arb_pkg.sv - shared FSM state type and default watchdog limit for mult_arbiter
package mult_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        BUSY  = 2'd2,
        RESP  = 2'd3
    } mult_arb_state_t;

    localparam int MULT_ARB_TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/mult_arbiter_rr_select.sv
// rtl/mult_arbiter_rr_select.sv - round-robin requester selector, search starts just after last grant
module rr_select
    import mult_arb_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last,
    output logic            found,
    output logic [IW-1:0]   grant
);

    logic [IW-1:0] idx;

    // Walk the ring from farthest to nearest so the nearest requester overwrites the result.
    always_comb begin
        found = 1'b0;
        grant = '0;
        idx   = '0;
        for (int k = NREQ; k >= 1; k--) begin
            idx = IW'((int'(last) + k) % NREQ);
            if (req[idx]) begin
                found = 1'b1;
                grant = idx;
            end
        end
    end

endmodule

// File: rtl/mult_arbiter.sv
// rtl/mult_arbiter.sv - round-robin arbiter sharing one multiplier among NREQ requesters
// Optional watchdog abort enabled by defining MULT_ARB_TIMEOUT_EN.
module mult_arbiter
    import mult_arb_pkg::*;
#(
    parameter int N              = 4,
    parameter int NREQ           = 2,
    parameter int TIMEOUT_CYCLES = MULT_ARB_TIMEOUT_DEFAULT
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*N-1:0] req_multiplicand,
    input  logic [NREQ*N-1:0] req_multiplier,
    output logic [NREQ-1:0]   req_ack,
    output logic [NREQ-1:0]   rsp_valid,
    output logic [2*N-1:0]    rsp_product,
    output logic [NREQ-1:0]   rsp_error,
    output logic              mult_start,
    output logic [N-1:0]      mult_multiplicand,
    output logic [N-1:0]      mult_multiplier,
    input  logic              mult_ready,
    input  logic [2*N-1:0]    mult_product
);

    localparam int IW = $clog2(NREQ);

    mult_arb_state_t state, state_next;
    logic [IW-1:0]   last_grant;
    logic [IW-1:0]   sel_grant;
    logic            sel_found;
    logic            do_grant;
    logic            done;
    logic            timeout;
    logic [N-1:0]    sel_multiplicand;
    logic [N-1:0]    sel_multiplier;

    rr_select #(.NREQ(NREQ), .IW(IW)) u_rr_select (
        .req   (req_valid),
        .last  (last_grant),
        .found (sel_found),
        .grant (sel_grant)
    );

    always_comb begin
        sel_multiplicand = '0;
        sel_multiplier   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (sel_grant == IW'(i)) begin
                sel_multiplicand = req_multiplicand[i*N +: N];
                sel_multiplier   = req_multiplier[i*N +: N];
            end
        end
    end

    assign do_grant   = (state == IDLE) && sel_found && mult_ready;
    assign done       = (state == BUSY) && mult_ready;
    assign mult_start = (state == START);
    assign rsp_valid  = (state == RESP) ? (NREQ'(1) << last_grant) : '0;

`ifdef MULT_ARB_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);

    logic [WW-1:0] watchdog;
    logic          in_op;

    assign in_op   = (state == START) || (state == BUSY);
    // A completing multiplier wins over a watchdog expiring in the same cycle.
    assign timeout = in_op && !done && (watchdog == WW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            watchdog  <= '0;
            rsp_error <= '0;
        end else begin
            watchdog  <= in_op ? watchdog + 1'b1 : '0;
            rsp_error <= timeout ? (NREQ'(1) << last_grant) : '0;
        end
    end
`else
    // No watchdog built: the FSM waits on the multiplier indefinitely.
    assign timeout   = (TIMEOUT_CYCLES < 0);
    assign rsp_error = '0;
`endif

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (do_grant) state_next = START;
            START:   if (timeout) state_next = IDLE;
                     else if (!mult_ready) state_next = BUSY;
            BUSY:    if (done) state_next = RESP;
                     else if (timeout) state_next = IDLE;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state             <= IDLE;
            last_grant        <= IW'(NREQ - 1);
            req_ack           <= '0;
            mult_multiplicand <= '0;
            mult_multiplier   <= '0;
            rsp_product       <= '0;
        end else begin
            state   <= state_next;
            req_ack <= do_grant ? (NREQ'(1) << sel_grant) : '0;
            if (do_grant) begin
                last_grant        <= sel_grant;
                mult_multiplicand <= sel_multiplicand;
                mult_multiplier   <= sel_multiplier;
            end
            if (done) begin
                rsp_product <= mult_product;
            end
        end
    end

endmodule

// File: tb/tb_mult_arbiter.sv
// tb/tb_mult_arbiter.sv - randomized self-checking bench for mult_arbiter with a behavioural multiplier
module tb_mult_arbiter;

    localparam int N    = 4;
    localparam int NREQ = 2;
    localparam int TO   = 8;

    logic              clock = 1'b0;
    logic              reset;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*N-1:0] req_multiplicand;
    logic [NREQ*N-1:0] req_multiplier;
    logic [NREQ-1:0]   req_ack;
    logic [NREQ-1:0]   rsp_valid;
    logic [2*N-1:0]    rsp_product;
    logic [NREQ-1:0]   rsp_error;
    logic              mult_start;
    logic [N-1:0]      mult_multiplicand;
    logic [N-1:0]      mult_multiplier;
    logic              mult_ready;
    logic [2*N-1:0]    mult_product;

    int n_cmp = 0;
    int n_bad = 0;
    int op_a[NREQ];
    int op_b[NREQ];
    int last_g;
    int busy_len = 0;
    int drop_dly = 0;
    bit mm_stuck = 1'b0;
    int mm_phase = 0;
    int mm_cnt = 0;
    logic [N-1:0] mm_a, mm_b;
    bit mm_bad_ops, mm_bad_start;
    int n_ack_seen = 0, n_rsp_seen = 0, n_err_seen = 0;
    int exp_ack = 0, exp_rsp = 0, exp_err = 0;

    always #5 clock = ~clock;

    mult_arbiter #(.N(N), .NREQ(NREQ), .TIMEOUT_CYCLES(TO)) dut (
        .clock             (clock),
        .reset             (reset),
        .req_valid         (req_valid),
        .req_multiplicand  (req_multiplicand),
        .req_multiplier    (req_multiplier),
        .req_ack           (req_ack),
        .rsp_valid         (rsp_valid),
        .rsp_product       (rsp_product),
        .rsp_error         (rsp_error),
        .mult_start        (mult_start),
        .mult_multiplicand (mult_multiplicand),
        .mult_multiplier   (mult_multiplier),
        .mult_ready        (mult_ready),
        .mult_product      (mult_product)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int rr_pick(input logic [NREQ-1:0] mask);
        for (int k = 1; k <= NREQ; k++) begin
            if (mask[(last_g + k) % NREQ]) return (last_g + k) % NREQ;
        end
        return 0;
    endfunction

    task automatic drive_ops();
        for (int i = 0; i < NREQ; i++) begin
            req_multiplicand[i*N +: N] = N'(op_a[i]);
            req_multiplier[i*N +: N]   = N'(op_b[i]);
        end
    endtask

    task automatic rand_ops();
        for (int i = 0; i < NREQ; i++) begin
            op_a[i] = $urandom_range(0, 15);
            op_b[i] = $urandom_range(0, 15);
        end
    endtask

    task automatic wait_ack();
        int cyc = 0;
        do begin
            @(negedge clock);
            cyc++;
        end while (req_ack == '0 && cyc < 20);
    endtask

    // Multiplier: drops ready drop_dly cycles after seeing start, stays low busy_len+1 samples.
    always @(posedge clock) begin
        #1;
        if (reset) begin
            mult_ready = 1'b1;
            mm_phase   = 0;
        end else begin
            case (mm_phase)
                0: if (mult_start && !mm_stuck) begin
                    mm_a = mult_multiplicand;
                    mm_b = mult_multiplier;
                    mm_bad_ops = 1'b0;
                    mm_bad_start = 1'b0;
                    if (drop_dly == 0) begin
                        mult_ready = 1'b0;
                        mm_cnt = busy_len;
                        mm_phase = 2;
                    end else begin
                        mm_cnt = drop_dly;
                        mm_phase = 1;
                    end
                end
                1: begin
                    if (!mult_start) mm_bad_start = 1'b1;
                    if (mult_multiplicand !== mm_a || mult_multiplier !== mm_b) mm_bad_ops = 1'b1;
                    mm_cnt--;
                    if (mm_cnt == 0) begin
                        mult_ready = 1'b0;
                        mm_cnt = busy_len;
                        mm_phase = 2;
                    end
                end
                default: begin
                    if (mult_start) mm_bad_start = 1'b1;
                    if (mult_multiplicand !== mm_a || mult_multiplier !== mm_b) mm_bad_ops = 1'b1;
                    if (mm_cnt == 0) begin
                        mult_product = (2*N)'(mm_a) * (2*N)'(mm_b);
                        mult_ready = 1'b1;
                        mm_phase = 0;
                        check("start_hold", 32'(mm_bad_start), 32'd0);
                        check("ops_stable", 32'(mm_bad_ops), 32'd0);
                    end else begin
                        mm_cnt--;
                    end
                end
            endcase
        end
    end

    always @(negedge clock) begin
        if (req_ack != '0) n_ack_seen++;
        if (rsp_valid != '0) n_rsp_seen++;
        if (rsp_error != '0) n_err_seen++;
    end

    task automatic run_round(input logic [NREQ-1:0] mask, input int bl, input int dd);
        int g, cyc, a, b;
        busy_len = bl;
        drop_dly = dd;
        @(negedge clock);
        drive_ops();
        req_valid = mask;
        g = rr_pick(mask);
        a = op_a[g];
        b = op_b[g];
        wait_ack();
        check("ack", 32'(req_ack), 32'd1 << g);
        exp_ack++;
        last_g = g;
        req_valid = '0;
        rand_ops();
        drive_ops();
        @(negedge clock);
        check("ack_pulse", 32'(req_ack), 32'd0);
        cyc = 0;
        while (rsp_valid == '0 && rsp_error == '0 && cyc < bl + dd + 20) begin
            @(negedge clock);
            cyc++;
        end
        check("rsp_valid", 32'(rsp_valid), 32'd1 << g);
        check("rsp_product", 32'(rsp_product), 32'(a * b));
        exp_rsp++;
        @(negedge clock);
        check("rsp_hold", 32'(rsp_product), 32'(a * b));
    endtask

    initial begin
        #5000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int g, cyc;
        reset = 1'b1;
        req_valid = '0;
        req_multiplicand = '0;
        req_multiplier = '0;
        mult_ready = 1'b1;
        mult_product = '0;
        last_g = NREQ - 1;
        repeat (3) @(negedge clock);
        check("reset_outs", {req_ack, rsp_valid, rsp_error, mult_start, mult_multiplicand,
                             mult_multiplier, rsp_product}, 32'd0);
        reset = 1'b0;

        // Single request 7x9
        rand_ops();
        op_a[0] = 7;
        op_b[0] = 9;
        run_round(2'b01, 2, 0);

        // Contention: both held, grants must alternate
        op_a[0] = 3;  op_b[0] = 5;
        op_a[1] = 15; op_b[1] = 15;
        busy_len = 2;
        drop_dly = 0;
        @(negedge clock);
        drive_ops();
        req_valid = 2'b11;
        for (int r = 0; r < 4; r++) begin
            g = rr_pick(2'b11);
            wait_ack();
            check("cont_ack", 32'(req_ack), 32'd1 << g);
            exp_ack++;
            last_g = g;
            cyc = 0;
            do begin
                @(negedge clock);
                cyc++;
            end while (rsp_valid == '0 && cyc < 30);
            check("cont_rsp", 32'(rsp_valid), 32'd1 << g);
            check("cont_prod", 32'(rsp_product), 32'(op_a[g] * op_b[g]));
            exp_rsp++;
            if (r == 3) req_valid = '0;
        end

        // Boundary operands
        op_a[0] = 0;  op_b[0] = 0;
        op_a[1] = 15; op_b[1] = 15;
        run_round(2'b01, 1, 0);
        op_a[0] = 0;  op_b[0] = 0;
        op_a[1] = 15; op_b[1] = 15;
        run_round(2'b10, 1, 1);

        // Reset in BUSY aborts with no response
        rand_ops();
        op_a[1] = 13; op_b[1] = 11;
        busy_len = 6;
        drop_dly = 0;
        @(negedge clock);
        drive_ops();
        req_valid = 2'b10;
        g = rr_pick(2'b10);
        wait_ack();
        check("rst_ack", 32'(req_ack), 32'd1 << g);
        exp_ack++;
        req_valid = '0;
        @(negedge clock);
        @(negedge clock);
        #1 reset = 1'b1;
        #1;
        check("rst_abort_outs", {req_ack, rsp_valid, rsp_error, mult_start, mult_multiplicand,
                                 mult_multiplier, rsp_product}, 32'd0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        last_g = NREQ - 1;
        rand_ops();
        run_round(2'b11, 1, 0);

        // Slow multiplier with start held two cycles before ready falls
        rand_ops();
        run_round(2'b01, 1000, 2);

`ifdef MULT_ARB_TIMEOUT_EN
        mm_stuck = 1'b1;
        rand_ops();
        @(negedge clock);
        drive_ops();
        req_valid = 2'b01;
        g = rr_pick(2'b01);
        wait_ack();
        check("to_ack", 32'(req_ack), 32'd1 << g);
        exp_ack++;
        last_g = g;
        req_valid = '0;
        cyc = 0;
        while (rsp_error == '0 && cyc < 50) begin
            @(negedge clock);
            cyc++;
        end
        check("to_cycles", 32'(cyc), 32'(TO));
        check("to_err", 32'(rsp_error), 32'd1 << g);
        check("to_valid", 32'(rsp_valid), 32'd0);
        exp_err++;
        mm_stuck = 1'b0;
        rand_ops();
        run_round(2'b11, 2, 1);
`endif

        // Randomized traffic
        for (int r = 0; r < 25; r++) begin
            rand_ops();
            run_round(2'($urandom_range(1, 3)), $urandom_range(0, 6), $urandom_range(0, 2));
        end

        @(negedge clock);
        check("ack_count", 32'(n_ack_seen), 32'(exp_ack));
        check("rsp_count", 32'(n_rsp_seen), 32'(exp_rsp));
        check("err_count", 32'(n_err_seen), 32'(exp_err));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
